// File: rtl/csi2_pkg.sv
// csi2_pkg: CSI-2 data types, sync byte, FSM/packet-kind enums and the header ECC.
// CSI2_LINE_SYNC_EN adds the Line Start / Line End packet kinds.
package csi2_pkg;
    localparam logic [5:0] DT_FS     = 6'h00;
    localparam logic [5:0] DT_FE     = 6'h01;
    localparam logic [5:0] DT_LS     = 6'h02;
    localparam logic [5:0] DT_LE     = 6'h03;
    localparam logic [5:0] DT_RAW10  = 6'h2B;
    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    typedef enum logic [3:0] {
        S_IDLE, S_SYNC, S_DI, S_WC0, S_WC1, S_ECC, S_PAYLOAD, S_CRC0, S_CRC1, S_GAP
    } state_e;

`ifdef CSI2_LINE_SYNC_EN
    typedef enum logic [2:0] {K_FS, K_LINE, K_FE, K_LS, K_LE} kind_e;
`else
    typedef enum logic [1:0] {K_FS, K_LINE, K_FE} kind_e;
`endif

    // Each mask selects the data bits feeding one parity bit of the 6-bit header ECC.
    function automatic logic [5:0] ecc6(input logic [23:0] d);
        ecc6[0] = ^(d & 24'hF12CB7);
        ecc6[1] = ^(d & 24'hF2555B);
        ecc6[2] = ^(d & 24'h749A6D);
        ecc6[3] = ^(d & 24'hB8E38E);
        ecc6[4] = ^(d & 24'hDF03F0);
        ecc6[5] = ^(d & 24'hEFFC00);
    endfunction
endpackage

// File: rtl/csi2_crc16_step.sv
// csi2_crc16_step: one-byte update of the reflected CRC-16 (poly 0x8408), shared with the RX checker.
module csi2_crc16_step (
    input  logic [15:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);
    logic [7:0] x;
    logic [7:0] t;

    assign x     = data_i ^ crc_i[7:0];
    assign t     = x ^ {x[3:0], 4'h0};
    assign crc_o = {t, crc_i[15:8]} ^ {12'h000, t[7:4]} ^ {5'h00, t, 3'h0};
endmodule

// File: rtl/csi2_packet_generator.sv
// csi2_packet_generator: gear-8 single-lane CSI-2 frame transmitter (FS, LINES long packets, FE).
// Define CSI2_LINE_SYNC_EN to wrap every line in Line Start / Line End short packets.
module csi2_packet_generator
    import csi2_pkg::*;
#(
    parameter int          LINE_BYTES = 16,
    parameter int          LINES      = 4,
    parameter logic [5:0]  DATA_TYPE  = 6'h2B,
    parameter logic [1:0]  VC         = 2'd0,
    parameter int          GAP_CYCLES = 8
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       start_i,
    input  logic [7:0] pixel_data_i,
    input  logic       pixel_valid_i,
    output logic       pixel_ready_o,
    output logic [7:0] data_lane0_o,
    output logic       data_valid_o,
    output logic       busy_o,
    output logic       frame_done_o,
    output logic       underflow_o
);
    localparam int BW = $clog2(LINE_BYTES + 1);
    localparam int LW = $clog2(LINES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [BW-1:0] BYTES_ALL = BW'(LINE_BYTES);
    localparam logic [LW-1:0] LINE_LAST = LW'(LINES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    state_e        state_q;
    kind_e         kind_q;
    kind_e         kind_nx;
    logic [15:0]   frame_num_q;
    logic [15:0]   crc_q;
    logic [15:0]   crc_d;
    logic [15:0]   wc;
    logic [7:0]    di;
    logic [7:0]    pay_byte;
    logic [7:0]    data_q;
    logic [BW-1:0] byte_q;
    logic [LW-1:0] line_q;
    logic [LW-1:0] line_nx;
    logic [GW-1:0] gap_q;
    logic          valid_q;
    logic          busy_q;
    logic          done_q;
    logic          under_q;

    assign pay_byte = pixel_valid_i ? pixel_data_i : 8'h00;

    csi2_crc16_step u_crc (
        .crc_i  (crc_q),
        .data_i (pay_byte),
        .crc_o  (crc_d)
    );

    always_comb begin
        di = {VC, kind_q == K_FS ? DT_FS : kind_q == K_FE ? DT_FE : DATA_TYPE};
        wc = kind_q == K_LINE ? 16'(LINE_BYTES) : frame_num_q;
`ifdef CSI2_LINE_SYNC_EN
        if (kind_q == K_LS || kind_q == K_LE) begin
            di = {VC, kind_q == K_LS ? DT_LS : DT_LE};
            wc = 16'(line_q) + 16'd1;
        end
`endif
    end

    // line_q counts completed lines; it is the 0-based number of the line in flight.
    always_comb begin
`ifdef CSI2_LINE_SYNC_EN
        kind_nx = kind_q == K_FS ? K_LS : kind_q == K_LS ? K_LINE : kind_q == K_LINE ? K_LE :
                  line_q == LINE_LAST ? K_FE : K_LS;
        line_nx = kind_q != K_LE ? line_q : line_q == LINE_LAST ? '0 : line_q + LW'(1);
`else
        kind_nx = (kind_q == K_LINE && line_q == LINE_LAST) ? K_FE : K_LINE;
        line_nx = kind_q != K_LINE ? line_q : line_q == LINE_LAST ? '0 : line_q + LW'(1);
`endif
    end

    assign pixel_ready_o = (state_q == S_ECC && kind_q == K_LINE) ||
                           (state_q == S_PAYLOAD && byte_q != BYTES_ALL);
    assign data_lane0_o  = data_q;
    assign data_valid_o  = valid_q;
    assign busy_o        = busy_q;
    assign frame_done_o  = done_q;
    assign underflow_o   = under_q;

    // Outputs are loaded with the byte belonging to the state being entered.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            kind_q      <= K_FS;
            frame_num_q <= 16'd1;
            crc_q       <= 16'hFFFF;
            byte_q      <= '0;
            line_q      <= '0;
            gap_q       <= '0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            under_q     <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            under_q <= 1'b0;
            valid_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    valid_q <= start_i;
                    data_q  <= start_i ? SYNC_BYTE : 8'h00;
                    if (start_i) begin
                        state_q <= S_SYNC;
                        kind_q  <= K_FS;
                        busy_q  <= 1'b1;
                        crc_q   <= 16'hFFFF;
                    end
                end
                S_SYNC: begin
                    state_q <= S_DI;
                    data_q  <= di;
                end
                S_DI: begin
                    state_q <= S_WC0;
                    data_q  <= wc[7:0];
                end
                S_WC0: begin
                    state_q <= S_WC1;
                    data_q  <= wc[15:8];
                end
                S_WC1: begin
                    state_q <= S_ECC;
                    data_q  <= {2'b00, ecc6({wc, di})};
                end
                S_ECC, S_PAYLOAD: begin
                    if (state_q == S_ECC && kind_q != K_LINE) begin
                        state_q <= S_GAP;
                        valid_q <= 1'b0;
                        data_q  <= 8'h00;
                        gap_q   <= GAP_LAST;
                        done_q  <= kind_q == K_FE && GAP_LAST == '0;
                    end else if (state_q == S_PAYLOAD && byte_q == BYTES_ALL) begin
                        state_q <= S_CRC0;
                        data_q  <= crc_q[7:0];
                    end else begin
                        state_q <= S_PAYLOAD;
                        data_q  <= pay_byte;
                        under_q <= !pixel_valid_i;
                        crc_q   <= crc_d;
                        byte_q  <= state_q == S_ECC ? BW'(1) : byte_q + BW'(1);
                    end
                end
                S_CRC0: begin
                    state_q <= S_CRC1;
                    data_q  <= crc_q[15:8];
                end
                S_CRC1: begin
                    state_q <= S_GAP;
                    valid_q <= 1'b0;
                    data_q  <= 8'h00;
                    gap_q   <= GAP_LAST;
                    done_q  <= kind_q == K_FE && GAP_LAST == '0;
                end
                S_GAP: begin
                    valid_q <= 1'b0;
                    data_q  <= 8'h00;
                    if (gap_q != '0) begin
                        gap_q  <= gap_q - GW'(1);
                        done_q <= kind_q == K_FE && gap_q == GW'(1);
                    end else if (kind_q == K_FE) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        frame_num_q <= frame_num_q == 16'hFFFF ? 16'd1 : frame_num_q + 16'd1;
                    end else begin
                        state_q <= S_SYNC;
                        valid_q <= 1'b1;
                        data_q  <= SYNC_BYTE;
                        crc_q   <= 16'hFFFF;
                        kind_q  <= kind_nx;
                        line_q  <= line_nx;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_csi2_packet_generator.sv
// tb_csi2_packet_generator: compares the generator byte stream every cycle against a packet-level model.
`timescale 1ns/1ps
module tb_csi2_packet_generator;
    localparam int         LB  = 4;
    localparam int         NL  = 2;
    localparam int         GAP = 8;
    localparam logic [5:0] DT  = 6'h2B;
    localparam logic [1:0] VCH = 2'd0;
    // ECC contribution of each of the 24 header data bits.
    localparam logic [5:0] ECC_COL [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19, 6'h1A, 6'h1C, 6'h23, 6'h25,
        6'h26, 6'h29, 6'h2A, 6'h2C, 6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

    typedef struct packed {
        logic       v;
        logic [7:0] b;
        logic       uf;
        logic       fd;
        logic       pay;
    } ent_t;

    logic       clk_i = 1'b0;
    logic       reset_n_i = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] pixel_data_i = 8'h00;
    logic       pixel_valid_i = 1'b0;
    logic       pixel_ready_o;
    logic [7:0] data_lane0_o;
    logic       data_valid_o;
    logic       busy_o;
    logic       frame_done_o;
    logic       underflow_o;

    ent_t        exp_q[$];
    logic [7:0]  cap[$];
    int          total = 0;
    int          bad = 0;
    int          k = 0;
    int          p = 0;
    int          uf_cnt = 0;
    int          fd_cnt = 0;
    logic [15:0] fn = 16'd1;
    logic        cur_pay = 1'b0;

    always #5 clk_i = ~clk_i;

    csi2_packet_generator #(
        .LINE_BYTES (LB),
        .LINES      (NL),
        .DATA_TYPE  (DT),
        .VC         (VCH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .start_i       (start_i),
        .pixel_data_i  (pixel_data_i),
        .pixel_valid_i (pixel_valid_i),
        .pixel_ready_o (pixel_ready_o),
        .data_lane0_o  (data_lane0_o),
        .data_valid_o  (data_valid_o),
        .busy_o        (busy_o),
        .frame_done_o  (frame_done_o),
        .underflow_o   (underflow_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [5:0] m_ecc(input logic [23:0] d);
        logic [5:0] r = 6'h00;
        for (int i = 0; i < 24; i++) if (d[i]) r ^= ECC_COL[i];
        return r;
    endfunction

    function automatic logic [15:0] m_crc(input logic [15:0] c, input logic [7:0] b);
        for (int i = 0; i < 8; i++) c = (c[0] ^ b[i]) ? (c >> 1) ^ 16'h8408 : c >> 1;
        return c;
    endfunction

    function automatic logic vmask(input int o);
        return !(o == 17 || o == 18);
    endfunction

    function automatic logic [7:0] pix(input int o);
        return 8'(o % LB);
    endfunction

    task automatic push(input logic v, input logic [7:0] b, input logic uf, input logic fd, input logic pay);
        ent_t e;
        e = '{v, b, uf, fd, pay};
        exp_q.push_back(e);
    endtask

    task automatic pkt(input logic [5:0] dt, input logic [15:0] wc, input logic long_pkt, input logic fe);
        logic [7:0]  di;
        logic [15:0] c;
        logic [7:0]  x;
        di = {VCH, dt};
        c  = 16'hFFFF;
        push(1, 8'hB8, 0, 0, 0);
        push(1, di, 0, 0, 0);
        push(1, wc[7:0], 0, 0, 0);
        push(1, wc[15:8], 0, 0, 0);
        push(1, {2'b00, m_ecc({wc, di})}, 0, 0, 0);
        if (long_pkt) begin
            for (int i = 0; i < LB; i++) begin
                x = vmask(p) ? pix(p) : 8'h00;
                push(1, x, !vmask(p), 0, 1);
                c = m_crc(c, x);
                p++;
            end
            push(1, c[7:0], 0, 0, 0);
            push(1, c[15:8], 0, 0, 0);
        end
        for (int i = 0; i < GAP; i++) push(0, 8'h00, 0, fe && i == GAP - 1, 0);
    endtask

    task automatic frame();
        pkt(6'h00, fn, 0, 0);
        for (int l = 1; l <= NL; l++) begin
`ifdef CSI2_LINE_SYNC_EN
            pkt(6'h02, 16'(l), 0, 0);
`endif
            pkt(DT, 16'(LB), 1, 0);
`ifdef CSI2_LINE_SYNC_EN
            pkt(6'h03, 16'(l), 0, 0);
`endif
        end
        pkt(6'h01, fn, 0, 1);
        fn = fn == 16'hFFFF ? 16'd1 : fn + 16'd1;
    endtask

    task automatic start_frame();
        @(negedge clk_i);
        cap.delete();
        uf_cnt  = 0;
        fd_cnt  = 0;
        start_i = 1'b1;
        frame();
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        chk("wait_idle", {exp_q.size() != 0, busy_o}, 0);
    endtask

    task automatic hdr(input string nm, input int off, input logic [39:0] want);
        if (off < 0 || off + 5 > cap.size()) begin
            chk({nm, "_len"}, cap.size(), off + 5);
        end else begin
            chk(nm, {cap[off], cap[off+1], cap[off+2], cap[off+3]}, want[39:8]);
            chk({nm, "_ecc"}, cap[off+4], want[7:0]);
        end
    endtask

    initial forever begin
        @(negedge clk_i);
        pixel_valid_i = vmask(k);
        pixel_data_i  = pix(k);
        if (pixel_ready_o) k++;
    end

    initial begin
        ent_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() == 0) begin
                chk("idle", {data_valid_o, data_lane0_o, underflow_o, frame_done_o, busy_o, pixel_ready_o}, 0);
                cur_pay = 1'b0;
            end else begin
                e = exp_q.pop_front();
                chk("stream", {data_valid_o, data_lane0_o, underflow_o, frame_done_o, busy_o, pixel_ready_o},
                    {e.v, e.b, e.uf, e.fd, 1'b1, (exp_q.size() > 0 && exp_q[0].pay)});
                cur_pay = e.pay;
            end
            if (data_valid_o) cap.push_back(data_lane0_o);
            uf_cnt += int'(underflow_o);
            fd_cnt += int'(frame_done_o);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] c;
        int          n;
        chk("ecc_fs1", m_ecc(24'h000100), 6'h1A);
        chk("ecc_line", m_ecc(24'h00042B), 6'h34);
        c = 16'hFFFF;
        for (int i = 0; i < 9; i++) c = m_crc(c, 8'h31 + 8'(i));
        chk("crc_check", c, 16'h6F91);
        repeat (3) @(negedge clk_i);
        reset_n_i = 1'b1;
        start_frame();
        wait_idle();
        hdr("fs1", 0, 40'hB8_00_01_00_1A);
        hdr("fe1", cap.size() - 5, 40'hB8_01_01_00_1D);
        chk("fd1", fd_cnt, 1);
        start_frame();
        repeat (10) @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk_i);
        hdr("fs2", 0, 40'hB8_00_02_00_1C);
        hdr("fe2", cap.size() - 5, 40'hB8_01_02_00_1B);
        chk("fd2", fd_cnt, 1);
        start_frame();
        wait_idle();
        chk("underflow_cnt", uf_cnt, 2);
        start_frame();
        n = 0;
        while (!cur_pay && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk("reach_payload", cur_pay, 1);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("rst_out", {data_valid_o, data_lane0_o, busy_o, frame_done_o, underflow_o}, 0);
        exp_q.delete();
        k  = 0;
        p  = 0;
        fn = 16'd1;
        repeat (3) @(negedge clk_i);
        reset_n_i = 1'b1;
        repeat (3) @(negedge clk_i);
        start_frame();
        wait_idle();
        hdr("fs_after_rst", 0, 40'hB8_00_01_00_1A);
        chk("fd_after_rst", fd_cnt, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/csi2_packet_generator.md
Name: csi2_packet_generator

Overview:
- Single-lane MIPI CSI-2 byte-stream transmitter (gear 8): the generating end of the stream that frame_detector consumes.
- On each start pulse it emits one complete frame:
  - Frame Start (FS) short packet,
  - LINES long packets of pixel payload,
  - Frame End (FE) short packet.
- Every packet is preceded by the 0xB8 sync byte and followed by an LP gap (valid low).
- Used as a sensor-free stimulus source for the receive path and as a loopback generator on the board.

Parameters:
- LINE_BYTES, 16: long-packet word count (payload bytes per line), 1..65535.
- LINES, 4: long packets per frame, 1..4095.
- DATA_TYPE, 6'h2B: DT of line packets (RAW10).
- VC, 2'd0: virtual channel placed in DI[7:6] of every packet.
- GAP_CYCLES, 8: valid-low cycles after every packet, minimum 1.

Ports:
- clk_i, input, 1: byte clock.
- reset_n_i, input, 1: asynchronous active-low reset.
- start_i, input, 1: frame request; sampled only in IDLE.
- pixel_data_i, input, 8: payload byte.
- pixel_valid_i, input, 1: payload byte available.
- pixel_ready_o, output, 1: payload byte consumed this cycle.
- data_lane0_o, output, 8: HS byte, registered.
- data_valid_o, output, 1: HS byte valid, registered.
- busy_o, output, 1: frame in progress.
- frame_done_o, output, 1: one-cycle pulse on the last gap cycle after FE.
- underflow_o, output, 1: one-cycle pulse for each payload byte substituted with 0x00.

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE.
  - frame_num = 16'd1; line and byte counters 0; CRC register 16'hFFFF.
  - Asserting reset mid-packet aborts immediately: no trailing bytes are sent.
- FSM states: IDLE, SYNC, DI, WC0, WC1, ECC, PAYLOAD, CRC0, CRC1, GAP. A packet-kind register holds FS, LINE or FE (LS/LE added with the option below).
- IDLE:
  - start_i=1 -> SYNC with kind=FS, busy_o=1.
  - start_i while busy is ignored and not queued.
- Latency: 0xB8 appears on data_lane0_o, with data_valid_o=1, in the cycle after start_i is sampled. Every subsequent state emits exactly one byte per cycle.
- Header bytes:
  - SYNC: 0xB8.
  - DI: {VC, DT}.
  - WC0 / WC1: WC[7:0] / WC[15:8].
  - ECC: {2'b00, ecc6({WC, DI})}, using the CSI-2 v1.x Hamming equations over a 24-bit word with DI in bits [7:0].
- Word count by packet kind:
  - FS and FE: WC = frame_num.
  - LINE: WC = LINE_BYTES.
- Short packets go ECC -> GAP. Long packets go ECC -> PAYLOAD.
- PAYLOAD runs for LINE_BYTES cycles:
  - pixel_ready_o=1 throughout.
  - If pixel_valid_i=1 the output byte is pixel_data_i; otherwise the byte is 0x00 and underflow_o pulses.
  - The stream never stalls.
  - CRC updates on every emitted payload byte.
- CRC:
  - CRC-16, polynomial x^16+x^12+x^5+1, LSB-first (reflected 0x8408), seed 0xFFFF, reseeded at each SYNC.
  - CRC0 emits CRC[7:0]; CRC1 emits CRC[15:8]; then GAP.
- GAP: data_valid_o=0 and data_lane0_o=0x00 for GAP_CYCLES cycles. The next state is chosen on exit:
  - After FS -> LINE.
  - After LINE with line count < LINES -> LINE, else FE.
  - After FE -> IDLE: frame_done_o pulses, busy_o clears the following cycle, and frame_num increments (wraps 0xFFFF -> 0x0001, skipping 0).
- Width rules:
  - Byte counter: clog2(LINE_BYTES+1) bits.
  - Line counter: clog2(LINES+1) bits.
  - No arithmetic overflow is permitted within the legal parameter ranges.

Optional Feature:
- Macro: CSI2_LINE_SYNC_EN.
- Defined: each LINE packet is wrapped by a Line Start short packet (DT 0x02) and a Line End short packet (DT 0x03), each with WC = line number starting at 1 and each followed by its own gap. The sequence is FS, {LS, LINE, LE} x LINES, FE.
- Undefined: LS/LE kinds and their logic are absent; the sequence is FS, LINE x LINES, FE.

Decomposition:
- Package csi2_pkg holds:
  - DT constants (DT_FS=6'h00, DT_FE=6'h01, DT_LS=6'h02, DT_LE=6'h03, DT_RAW10=6'h2B);
  - SYNC_BYTE=8'hB8;
  - function ecc6(input [23:0]).
- Sub-module csi2_crc16_step: combinational next-CRC from the current CRC and one byte. It is shared with the receive-side CRC checker.

Test Plan:
- Reset, one start pulse, LINE_BYTES=4, LINES=2, pixel_valid_i=1 with data 0x00..0x03:
  - Expect B8 00 01 00 1A (FS, frame 1, ECC 0x1A).
  - Then 8 gap cycles.
  - Then B8 2B 04 00 ecc, payload 00 01 02 03, CRC matching the golden model, twice.
  - Then FE B8 01 01 00 ecc; frame_done_o pulses once.
- Two back-to-back frames: the second FS and FE carry WC=0x0002. A start_i asserted while busy_o=1 produces no extra frame.
- pixel_valid_i held low for 2 cycles mid-payload: those bytes are 0x00, underflow_o pulses twice, and the CRC covers the substituted zeros.
- Assert reset_n_i low during PAYLOAD:
  - Outputs go to 0 immediately; release returns to IDLE.
  - The next frame restarts at frame_num 1.
- With CSI2_LINE_SYNC_EN defined: the sequence is FS, LS(WC=1), LINE, LE(WC=1), LS(WC=2), LINE, LE(WC=2), FE. Feeding this sequence to frame_detector asserts its frame-sync detection.
